deu_gpr_mp: RTL and testbench
=============================

Name: deu_gpr_mp

Overview:
Parametrised multi-port general-purpose register file with an integrated busy scoreboard for the decode/execute unit (deu).
- Generalises the fixed 4-read/3-write GPR array to NUM_RD read and NUM_WR write ports, configurable width and depth.
- Adds optional write-to-read bypass, deterministic write-collision priority and per-register pending-write (busy) tracking.
- Issue logic uses the busy tracking to stall on RAW hazards.

Parameters:
NUM_RD, 4, number of read ports
NUM_WR, 3, number of write ports
DATA_W, `LA64_DATA_WIDTH (64), register width in bits
NUM_REG, `LA64_ARF_NUM (32), number of architectural registers; reg 0 hardwired to zero
ADDR_W, $clog2(NUM_REG), register address width
NUM_ALLOC, 2, number of busy-allocate ports (one per issue slot)
BYPASS, 1, 1 = same-cycle write data forwarded to matching reads

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
re  in  NUM_RD  per-port read enable
raddr  in  NUM_RD x ADDR_W  read addresses
rdata  out  NUM_RD x DATA_W  read data (combinational)
rbusy  out  NUM_RD  read register has pending write (combinational)
we  in  NUM_WR  per-port write enable
waddr  in  NUM_WR x ADDR_W  write addresses
wdata  in  NUM_WR x DATA_W  write data
alloc_v  in  NUM_ALLOC  mark destination register busy
alloc_addr  in  NUM_ALLOC x ADDR_W  destination register to mark
flush  in  1  clear entire scoreboard (pipeline flush)
busy_vec  out  NUM_REG  current scoreboard state (bit 0 always 0)

Behaviour:
- Clock/reset: single clock clk. rst_n is synchronous, active-low. Sampled low at a rising edge: all registers := 0, all busy bits := 0. Reset overrides any same-cycle write, alloc or flush.
- Outputs after reset: rdata = 0, rbusy = 0, busy_vec = 0.
- Reg 0: reads return 0. Writes and allocs to addr 0 are dropped. busy[0] is constant 0.
- Read: combinational.
  - rdata[p] = 0 when re[p]=0 or raddr[p]=0 or raddr[p] >= NUM_REG.
  - Otherwise rdata[p] = reg[raddr[p]].
  - BYPASS=1: if any we[k] && waddr[k]==raddr[p] != 0 this cycle, rdata[p] = wdata of the highest-index matching k.
- Write: register updated at the rising edge; visible next cycle, or same cycle with BYPASS=1.
  - Write collision (several ports, same addr, same cycle): highest-index port wins, no OR-merge.
  - waddr >= NUM_REG is ignored.
- Scoreboard, next-state per reg i != 0, evaluated in priority order:
  1. flush: busy := 0 for all registers (allocs this cycle ignored).
  2. any alloc_v[a] with alloc_addr[a]==i: busy[i] := 1 (new producer; wins over a same-cycle write to i).
  3. any we[k] with waddr[k]==i: busy[i] := 0.
  4. otherwise hold.
  - A write to a non-busy register is legal and updates data only.
  - Duplicate alloc addresses within a cycle are harmless.
- rbusy[p]:
  - 0 when re[p]=0 or raddr[p]=0.
  - Otherwise busy[raddr[p]] with BYPASS=0.
  - With BYPASS=1: busy[raddr[p]] & ~(same-cycle write hit on raddr[p]).
  - Same-cycle allocs do not affect rbusy (takes effect next cycle).
- No internal FSM beyond the per-register busy flops. Latency: write→read 1 cycle (0 with BYPASS); alloc→busy 1 cycle; write→busy clear 1 cycle.

Decomposition:
- Package deu_pkg: reuse `LA64_DATA_WIDTH / `LA64_ARF_NUM / `LA64_ARF_SEL from constants.vh; add gpr_addr_t and gpr_data_t typedefs.
- Sub-module deu_gpr_wsel: per-register write-port priority select producing {en, data}, generated NUM_REG-1 times.
- Storage uses the existing dff cell per register; busy flops live inline in the top level.

Test Plan:
1. Reset/r0: hold rst_n=0 with we[0]=1, waddr=5, wdata=0xAA. Release, read raddr=5 → rdata 0, busy_vec=0. Write r0=0xFF → read r0 returns 0.
2. Basic write/read: write r7=0x1234_5678_9ABC_DEF0 on port 1 → next cycle all 4 read ports on addr 7 return that value. re=0 → rdata 0.
3. Collision and bypass: same cycle, port0 r3=0x11, port2 r3=0x33, BYPASS=1 → same-cycle read r3 = 0x33; next cycle reg r3 = 0x33. With BYPASS=0, the same-cycle read returns the old value.
4. Scoreboard:
   - alloc r9 → next cycle rbusy=1 for raddr=9.
   - Write r9=0x55 → same-cycle rbusy=0 (BYPASS=1) with rdata 0x55; busy_vec[9]=0 next cycle.
5. Alloc/write race and flush:
   - Same cycle alloc r4 + write r4 → busy_vec[4]=1 next cycle.
   - Then flush with alloc r6 → busy_vec all 0.
6. Mid-operation reset: registers r1..r31 loaded, r2/r8 busy; assert rst_n=0 for one cycle alongside a write → all regs 0, busy_vec 0, write lost.

Source files
------------

// File: rtl/deu_gpr_mp_pkg.sv
// Shared sizing constants and typedefs for the decode/execute GPR file.
// Defaults match the LA64 architectural register file.
package deu_pkg;
    localparam int LA64_DATA_WIDTH = 64;
    localparam int LA64_ARF_NUM    = 32;
    localparam int LA64_ARF_SEL    = $clog2(LA64_ARF_NUM);

    typedef logic [LA64_ARF_SEL-1:0]    gpr_addr_t;
    typedef logic [LA64_DATA_WIDTH-1:0] gpr_data_t;
endpackage

// File: rtl/deu_gpr_mp_wsel.sv
// Write-port select for one register: reports whether any port targets it
// this cycle and which data lands, the highest-index matching port winning.
module deu_gpr_wsel #(
    parameter int NUM_WR = 3,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int IDX    = 1
) (
    input  logic [NUM_WR-1:0]             i_we,
    input  logic [NUM_WR-1:0][ADDR_W-1:0] i_waddr,
    input  logic [NUM_WR-1:0][DATA_W-1:0] i_wdata,
    output logic                          o_en,
    output logic [DATA_W-1:0]             o_data
);
    always_comb begin
        o_en   = 1'b0;
        o_data = '0;
        // Ascending scan: later matches overwrite earlier ones.
        for (int k = 0; k < NUM_WR; k++) begin
            if (i_we[k] && i_waddr[k] == ADDR_W'(IDX)) begin
                o_en   = 1'b1;
                o_data = i_wdata[k];
            end
        end
    end
endmodule

// File: rtl/deu_gpr_mp.sv
// Multi-port GPR file with write-to-read bypass and a per-register busy
// scoreboard used by issue to stall on RAW hazards. Register 0 reads as zero.
module deu_gpr_mp
    import deu_pkg::*;
#(
    parameter int NUM_RD    = 4,
    parameter int NUM_WR    = 3,
    parameter int DATA_W    = LA64_DATA_WIDTH,
    parameter int NUM_REG   = LA64_ARF_NUM,
    parameter int ADDR_W    = $clog2(NUM_REG),
    parameter int NUM_ALLOC = 2,
    parameter bit BYPASS    = 1'b1
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [NUM_RD-1:0]                i_re,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]    i_raddr,
    output logic [NUM_RD-1:0][DATA_W-1:0]    o_rdata,
    output logic [NUM_RD-1:0]                o_rbusy,
    input  logic [NUM_WR-1:0]                i_we,
    input  logic [NUM_WR-1:0][ADDR_W-1:0]    i_waddr,
    input  logic [NUM_WR-1:0][DATA_W-1:0]    i_wdata,
    input  logic [NUM_ALLOC-1:0]             i_alloc_v,
    input  logic [NUM_ALLOC-1:0][ADDR_W-1:0] i_alloc_addr,
    input  logic                             i_flush,
    output logic [NUM_REG-1:0]               o_busy_vec
);
    logic [NUM_REG-1:1][DATA_W-1:0] r_regs;
    logic [NUM_REG-1:0]             r_busy;

    logic [NUM_REG-1:1]             w_wen;
    logic [NUM_REG-1:1][DATA_W-1:0] w_wdat;
    logic [NUM_REG-1:1]             w_alloc;

    for (genvar i = 1; i < NUM_REG; i++) begin : g_wsel
        deu_gpr_wsel #(
            .NUM_WR (NUM_WR),
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .IDX    (i)
        ) u_wsel (
            .i_we    (i_we),
            .i_waddr (i_waddr),
            .i_wdata (i_wdata),
            .o_en    (w_wen[i]),
            .o_data  (w_wdat[i])
        );
    end

    always_comb begin
        w_alloc = '0;
        for (int i = 1; i < NUM_REG; i++) begin
            for (int a = 0; a < NUM_ALLOC; a++) begin
                if (i_alloc_v[a] && i_alloc_addr[a] == ADDR_W'(i)) w_alloc[i] = 1'b1;
            end
        end
    end

    // r_busy[0] is only ever cleared, so it stays 0 for good.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_regs <= '0;
            r_busy <= '0;
        end else begin
            for (int i = 1; i < NUM_REG; i++) begin
                if (w_wen[i]) r_regs[i] <= w_wdat[i];
            end
            if (i_flush) begin
                r_busy <= '0;
            end else begin
                for (int i = 1; i < NUM_REG; i++) begin
                    if (w_alloc[i])     r_busy[i] <= 1'b1;
                    else if (w_wen[i])  r_busy[i] <= 1'b0;
                end
            end
        end
    end

    assign o_busy_vec = r_busy;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [DATA_W-1:0] w_d;
        logic              w_b;
        logic              w_ok;
        logic              w_hit;

        // w_ok doubles as the range check: only addresses 1..NUM_REG-1 match.
        always_comb begin
            w_d   = '0;
            w_b   = 1'b0;
            w_ok  = 1'b0;
            w_hit = 1'b0;
            if (i_re[p]) begin
                for (int i = 1; i < NUM_REG; i++) begin
                    if (i_raddr[p] == ADDR_W'(i)) begin
                        w_ok = 1'b1;
                        w_d  = r_regs[i];
                        w_b  = r_busy[i];
                    end
                end
                if (BYPASS && w_ok) begin
                    for (int k = 0; k < NUM_WR; k++) begin
                        if (i_we[k] && i_waddr[k] == i_raddr[p]) begin
                            w_d   = i_wdata[k];
                            w_hit = 1'b1;
                        end
                    end
                end
            end
        end

        assign o_rdata[p] = w_d;
        assign o_rbusy[p] = w_b & ~w_hit;
    end
endmodule

// File: tb/tb_deu_gpr_mp.sv
// Randomised and directed checks of deu_gpr_mp (bypass and non-bypass
// instances sharing stimulus) against an array-based reference model.
module tb_deu_gpr_mp;
    localparam int NRD = 4, NWR = 3, DW = 64, NREG = 32, AW = 5, NAL = 2;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NRD-1:0]          re;
    logic [NRD-1:0][AW-1:0]  raddr;
    logic [NWR-1:0]          we;
    logic [NWR-1:0][AW-1:0]  waddr;
    logic [NWR-1:0][DW-1:0]  wdata;
    logic [NAL-1:0]          alloc_v;
    logic [NAL-1:0][AW-1:0]  alloc_addr;
    logic                    flush;

    logic [NRD-1:0][DW-1:0]  rdata_b, rdata_n;
    logic [NRD-1:0]          rbusy_b, rbusy_n;
    logic [NREG-1:0]         busy_b, busy_n;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0]   m_reg [NREG];
    logic [NREG-1:0] m_busy;

    always #5 clk = ~clk;

    deu_gpr_mp #(.BYPASS(1'b1)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_re(re), .i_raddr(raddr),
        .o_rdata(rdata_b), .o_rbusy(rbusy_b), .i_we(we), .i_waddr(waddr),
        .i_wdata(wdata), .i_alloc_v(alloc_v), .i_alloc_addr(alloc_addr),
        .i_flush(flush), .o_busy_vec(busy_b)
    );

    deu_gpr_mp #(.BYPASS(1'b0)) u_dut_n (
        .i_clk(clk), .i_rst_n(rst_n), .i_re(re), .i_raddr(raddr),
        .o_rdata(rdata_n), .o_rbusy(rbusy_n), .i_we(we), .i_waddr(waddr),
        .i_wdata(wdata), .i_alloc_v(alloc_v), .i_alloc_addr(alloc_addr),
        .i_flush(flush), .o_busy_vec(busy_n)
    );

    // Reference model: architectural state as plain arrays.
    function automatic logic [DW-1:0] exp_rd(int p, bit byp);
        logic [DW-1:0] v;
        int a = int'(raddr[p]);
        if (!re[p] || a == 0) return '0;
        v = m_reg[a];
        if (byp) for (int k = 0; k < NWR; k++) if (we[k] && int'(waddr[k]) == a) v = wdata[k];
        return v;
    endfunction

    function automatic logic exp_rb(int p, bit byp);
        logic b;
        int a = int'(raddr[p]);
        if (!re[p] || a == 0) return 1'b0;
        b = m_busy[a];
        if (byp) for (int k = 0; k < NWR; k++) if (we[k] && int'(waddr[k]) == a) b = 1'b0;
        return b;
    endfunction

    task automatic commit();
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) m_reg[i] = '0;
            m_busy = '0;
        end else begin
            for (int k = 0; k < NWR; k++) if (we[k] && waddr[k] != 0) m_reg[int'(waddr[k])] = wdata[k];
            if (flush) m_busy = '0;
            else begin
                for (int k = 0; k < NWR; k++) if (we[k]) m_busy[int'(waddr[k])] = 1'b0;
                for (int a = 0; a < NAL; a++) if (alloc_v[a]) m_busy[int'(alloc_addr[a])] = 1'b1;
            end
            m_busy[0] = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        commit();
        #1;
    endtask

    task automatic idle();
        rst_n = 1'b1; re = '0; raddr = '0; we = '0; waddr = '0; wdata = '0;
        alloc_v = '0; alloc_addr = '0; flush = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0; we[0] = 1'b1; waddr[0] = 5'd5; wdata[0] = 64'hAA;
        tick(); tick();
        idle(); re[0] = 1'b1; raddr[0] = 5'd5; #1;
        n_cmp++; if (rdata_b[0] !== 64'h0) begin n_err++; $display("FAIL reset_r5: got %h want 0", rdata_b[0]); end
        n_cmp++; if (busy_b !== '0 || busy_n !== '0) begin n_err++; $display("FAIL reset_busy: got %h/%h want 0", busy_b, busy_n); end
        n_cmp++; if (rbusy_b !== '0) begin n_err++; $display("FAIL reset_rbusy: got %b want 0", rbusy_b); end
        we[0] = 1'b1; waddr[0] = 5'd0; wdata[0] = 64'hFF; raddr[0] = 5'd0; #1;
        n_cmp++; if (rdata_b[0] !== 64'h0) begin n_err++; $display("FAIL r0_bypass: got %h want 0", rdata_b[0]); end
        tick(); we = '0; #1;
        n_cmp++; if (rdata_b[0] !== 64'h0 || rdata_n[0] !== 64'h0) begin n_err++; $display("FAIL r0_read: got %h/%h want 0", rdata_b[0], rdata_n[0]); end
    endtask

    task automatic test_basic_rw();
        idle(); we[1] = 1'b1; waddr[1] = 5'd7; wdata[1] = 64'h1234_5678_9ABC_DEF0;
        tick(); idle();
        re = '1; for (int p = 0; p < NRD; p++) raddr[p] = 5'd7; #1;
        for (int p = 0; p < NRD; p++) begin
            n_cmp++;
            if (rdata_n[p] !== 64'h1234_5678_9ABC_DEF0) begin
                n_err++; $display("FAIL basic_rd p%0d: got %h want 123456789abcdef0", p, rdata_n[p]);
            end
        end
        re = '0; #1;
        n_cmp++; if (rdata_b !== '0) begin n_err++; $display("FAIL re_off: got %h want 0", rdata_b); end
    endtask

    task automatic test_collision_bypass();
        logic [DW-1:0] old;
        idle(); old = m_reg[3];
        we = 3'b101; waddr[0] = 5'd3; wdata[0] = 64'h11; waddr[2] = 5'd3; wdata[2] = 64'h33;
        re[0] = 1'b1; raddr[0] = 5'd3; #1;
        n_cmp++; if (rdata_b[0] !== 64'h33) begin n_err++; $display("FAIL coll_bypass: got %h want 33", rdata_b[0]); end
        n_cmp++; if (rdata_n[0] !== old) begin n_err++; $display("FAIL coll_nobypass: got %h want %h", rdata_n[0], old); end
        tick(); we = '0; #1;
        n_cmp++; if (rdata_n[0] !== 64'h33 || rdata_b[0] !== 64'h33) begin n_err++; $display("FAIL coll_stored: got %h/%h want 33", rdata_n[0], rdata_b[0]); end
    endtask

    task automatic test_scoreboard();
        idle(); alloc_v[0] = 1'b1; alloc_addr[0] = 5'd9;
        re[1] = 1'b1; raddr[1] = 5'd9; #1;
        n_cmp++; if (rbusy_b[1] !== 1'b0) begin n_err++; $display("FAIL alloc_same_cycle: got %b want 0", rbusy_b[1]); end
        tick(); alloc_v = '0; #1;
        n_cmp++; if (rbusy_b[1] !== 1'b1 || rbusy_n[1] !== 1'b1) begin n_err++; $display("FAIL alloc_busy: got %b/%b want 1", rbusy_b[1], rbusy_n[1]); end
        we[0] = 1'b1; waddr[0] = 5'd9; wdata[0] = 64'h55; #1;
        n_cmp++; if (rbusy_b[1] !== 1'b0 || rdata_b[1] !== 64'h55) begin n_err++; $display("FAIL wr_bypass: got %b %h want 0 55", rbusy_b[1], rdata_b[1]); end
        n_cmp++; if (rbusy_n[1] !== 1'b1) begin n_err++; $display("FAIL wr_nobypass_busy: got %b want 1", rbusy_n[1]); end
        tick(); we = '0; #1;
        n_cmp++; if (busy_b[9] !== 1'b0 || rbusy_n[1] !== 1'b0) begin n_err++; $display("FAIL busy_clear: got %b/%b want 0", busy_b[9], rbusy_n[1]); end
    endtask

    task automatic test_race_flush();
        idle(); alloc_v[1] = 1'b1; alloc_addr[1] = 5'd4; we[2] = 1'b1; waddr[2] = 5'd4; wdata[2] = 64'h44;
        tick(); idle(); #1;
        n_cmp++; if (busy_b[4] !== 1'b1) begin n_err++; $display("FAIL race_alloc_wins: got %b want 1", busy_b[4]); end
        flush = 1'b1; alloc_v[0] = 1'b1; alloc_addr[0] = 5'd6;
        tick(); idle(); #1;
        n_cmp++; if (busy_b !== '0 || busy_n !== '0) begin n_err++; $display("FAIL flush: got %h/%h want 0", busy_b, busy_n); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            idle();
            re = NRD'($urandom);
            for (int p = 0; p < NRD; p++) raddr[p] = AW'(($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 7));
            we = NWR'($urandom);
            for (int k = 0; k < NWR; k++) begin
                waddr[k] = AW'(($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 7));
                wdata[k] = {$urandom, $urandom};
            end
            alloc_v = NAL'($urandom);
            for (int a = 0; a < NAL; a++) alloc_addr[a] = AW'(($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 7));
            flush = ($urandom_range(0, 15) == 0);
            #1;
            for (int p = 0; p < NRD; p++) begin
                n_cmp++;
                if (rdata_b[p] !== exp_rd(p, 1'b1) || rbusy_b[p] !== exp_rb(p, 1'b1)) begin
                    n_err++; $display("FAIL rand_byp c%0d p%0d: got %h/%b want %h/%b", c, p, rdata_b[p], rbusy_b[p], exp_rd(p, 1'b1), exp_rb(p, 1'b1));
                end
                n_cmp++;
                if (rdata_n[p] !== exp_rd(p, 1'b0) || rbusy_n[p] !== exp_rb(p, 1'b0)) begin
                    n_err++; $display("FAIL rand_nobyp c%0d p%0d: got %h/%b want %h/%b", c, p, rdata_n[p], rbusy_n[p], exp_rd(p, 1'b0), exp_rb(p, 1'b0));
                end
            end
            n_cmp++;
            if (busy_b !== m_busy || busy_n !== m_busy) begin
                n_err++; $display("FAIL rand_busy c%0d: got %h/%h want %h", c, busy_b, busy_n, m_busy);
            end
            tick();
        end
    endtask

    task automatic test_mid_reset();
        for (int a = 1; a < NREG; a += NWR) begin
            idle();
            for (int k = 0; k < NWR; k++) if (a + k < NREG) begin
                we[k] = 1'b1; waddr[k] = AW'(a + k); wdata[k] = {32'hC0DE_0000, 32'(a + k)};
            end
            tick();
        end
        idle(); alloc_v = 2'b11; alloc_addr[0] = 5'd2; alloc_addr[1] = 5'd8;
        tick(); idle(); re = '1; raddr[0] = 5'd2; raddr[1] = 5'd8; raddr[2] = 5'd31; raddr[3] = 5'd17; #1;
        n_cmp++; if (busy_b !== 32'h0000_0104) begin n_err++; $display("FAIL pre_reset_busy: got %h want 00000104", busy_b); end
        n_cmp++; if (rdata_n[2] !== {32'hC0DE_0000, 32'd31}) begin n_err++; $display("FAIL pre_reset_r31: got %h want c0de00000000001f", rdata_n[2]); end
        idle(); rst_n = 1'b0; we[0] = 1'b1; waddr[0] = 5'd10; wdata[0] = 64'hDEAD;
        tick(); idle(); re = '1;
        for (int a = 0; a < NREG; a += NRD) begin
            for (int p = 0; p < NRD; p++) raddr[p] = AW'(a + p);
            #1;
            n_cmp++;
            if (rdata_b !== '0 || rdata_n !== '0) begin
                n_err++; $display("FAIL post_reset_rd base%0d: got %h want 0", a, rdata_n);
            end
        end
        n_cmp++; if (busy_b !== '0 || rbusy_b !== '0) begin n_err++; $display("FAIL post_reset_busy: got %h/%b want 0", busy_b, rbusy_b); end
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) m_reg[i] = '0;
        m_busy = '0;
        idle(); rst_n = 1'b0;
        test_reset();
        test_basic_rw();
        test_collision_bypass();
        test_scoreboard();
        test_race_flush();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
